t05_huffman_decoder: RTL and testbench

- Reverse direction of the codebook/header synthesis path. Decodes a serial Huffman bitstream back into 8-bit characters.
- For each symbol, walks the stored Huffman tree from the root node to a leaf.
- Reads tree nodes through a request/acknowledge port. That port is compatible with the SRAM-side node fetch used by codebook synthesis.
- Emits each decoded character on a valid/ready output.

---
 rtl/t05_huff_pkg.sv | 44 ++++
 rtl/t05_huffman_decoder.sv | 143 ++++++++++++++
 tb/tb_t05_huffman_decoder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t05_huff_pkg.sv
// Shared types, htree node field layout and child-decode helpers for the Huffman decoder.
package t05_huff_pkg;

    localparam int unsigned DEF_NODE_W = 71;
    localparam int unsigned DEF_IDX_W  = 7;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam int unsigned MAXIDX_HI = 70;
    localparam int unsigned MAXIDX_LO = 64;
    localparam int unsigned LEFT_HI   = 63;
    localparam int unsigned LEFT_LO   = 55;
    localparam int unsigned RIGHT_HI  = 54;
    localparam int unsigned RIGHT_LO  = 46;
    localparam int unsigned CHILD_W   = 9;

    // A root whose right field holds this marks a one-symbol tree.
    localparam logic [CHILD_W-1:0] NULL_CHILD = 9'h180;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StBit,
        StEmit,
        StDone,
        StError
    } huff_state_e;

    function automatic logic [CHILD_W-1:0] select_child(input logic [CHILD_W-1:0] left,
                                                        input logic [CHILD_W-1:0] right,
                                                        input logic               bit_val,
                                                        input logic               is_root);
        logic [CHILD_W-1:0] res;
        res = left;
        if (bit_val && !(is_root && right == NULL_CHILD)) begin
            res = right;
        end
        return res;
    endfunction

    function automatic logic child_is_internal(input logic [CHILD_W-1:0] child);
        return child[CHILD_W-1];
    endfunction

endpackage

// File: rtl/t05_huffman_decoder.sv
// Serial Huffman decoder: walks the stored htree from the root per symbol, fetching nodes
// over a req/ack port and emitting each decoded character on a valid/ready output.
module t05_huffman_decoder
    import t05_huff_pkg::*;
#(
    parameter int unsigned NODE_W = DEF_NODE_W,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [IDX_W-1:0]  max_index_i,
    input  logic [CNT_W-1:0]  num_chars_i,
    input  logic              bit_in_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    output logic              node_req_o,
    output logic [IDX_W-1:0]  node_addr_o,
    input  logic [NODE_W-1:0] node_data_i,
    input  logic              node_ack_i,
    output logic [7:0]        char_out_o,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  chars_done_o
);

    huff_state_e              state_q, state_d;
    logic [IDX_W-1:0]         root_q, root_d;
    logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0]         num_q, num_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2*CHILD_W-1:0]     kids_q, kids_d;
    logic [7:0]               char_q, char_d;
    logic [CHILD_W-1:0]       child;
    logic [CNT_W-1:0]         cnt_inc;

    // Only the two child fields steer the walk; max_index and sum are not needed here.
    logic unused_node_bits;
    assign unused_node_bits = ^{node_data_i[MAXIDX_HI:MAXIDX_LO], node_data_i[RIGHT_LO-1:0]};

    assign child   = select_child(kids_q[2*CHILD_W-1:CHILD_W], kids_q[CHILD_W-1:0], bit_in_i,
                                  cur_idx_q == root_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        root_d       = root_q;
        cur_idx_d    = cur_idx_q;
        num_d        = num_q;
        cnt_d        = cnt_q;
        kids_d       = kids_q;
        char_d       = char_q;
        bit_ready_o  = 1'b0;
        node_req_o   = 1'b0;
        node_addr_o  = '0;
        char_valid_o = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                done_o = (state_q == StDone);
                if (start_i) begin
                    root_d    = max_index_i;
                    num_d     = num_chars_i;
                    cur_idx_d = max_index_i;
                    cnt_d     = '0;
                    state_d   = (num_chars_i == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                node_req_o  = 1'b1;
                node_addr_o = cur_idx_q;
                if (node_ack_i) begin
                    kids_d  = {node_data_i[LEFT_HI:LEFT_LO], node_data_i[RIGHT_HI:RIGHT_LO]};
                    state_d = StBit;
                end
            end
            StBit: begin
                bit_ready_o = 1'b1;
                if (bit_valid_i) begin
                    if (child_is_internal(child)) begin
                        // Child value[7] is not part of a node index.
                        if (child[IDX_W-1:0] > root_q) begin
                            state_d = StError;
                        end else begin
                            cur_idx_d = child[IDX_W-1:0];
                            state_d   = StFetch;
                        end
                    end else begin
                        char_d  = child[7:0];
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                char_valid_o = 1'b1;
                if (char_ready_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = StDone;
                    end else begin
                        cur_idx_d = root_q;
                        state_d   = StFetch;
                    end
                end
            end
            StError: begin
                err_o = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign char_out_o   = char_q;
    assign chars_done_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            root_q    <= '0;
            cur_idx_q <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            kids_q    <= '0;
            char_q    <= '0;
        end else begin
            state_q   <= state_d;
            root_q    <= root_d;
            cur_idx_q <= cur_idx_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            kids_q    <= kids_d;
            char_q    <= char_d;
        end
    end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Directed, table-driven bench for t05_huffman_decoder with a behavioural node memory,
// a bit-stream source with optional gaps and a character sink with optional stall.
module tb_t05_huffman_decoder;

    localparam int NW = 71;
    localparam int IW = 7;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] max_index;
    logic [CW-1:0] num_chars;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          node_req;
    logic [IW-1:0] node_addr;
    logic [NW-1:0] node_data;
    logic          node_ack;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready;
    logic          done;
    logic          err;
    logic [CW-1:0] chars_done;

    always #5 clk = ~clk;

    t05_huffman_decoder dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .max_index_i  (max_index),
        .num_chars_i  (num_chars),
        .bit_in_i     (bit_in),
        .bit_valid_i  (bit_valid),
        .bit_ready_o  (bit_ready),
        .node_req_o   (node_req),
        .node_addr_o  (node_addr),
        .node_data_i  (node_data),
        .node_ack_i   (node_ack),
        .char_out_o   (char_out),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .done_o       (done),
        .err_o        (err),
        .chars_done_o (chars_done)
    );

    // Node memory: ack after mem_delay cycles of a held request (0 = same cycle).
    logic [NW-1:0] mem [0:127];
    int            mem_delay;
    int            wait_cnt;

    assign node_ack  = node_req && (wait_cnt >= mem_delay);
    assign node_data = mem[node_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= 0;
        else if (node_req && !node_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    typedef struct {
        int          tree;
        logic [6:0]  root;
        logic [15:0] nch;
        logic [15:0] bits;       // first bit at position nbits-1
        int          nbits;
        int          delay;
        int          gap;
        int          stall;
        logic [31:0] exp_chars;  // first char in [31:24]
        logic        exp_err;
        int          exp_cyc;    // 0: latency not checked
    } vec_t;

    vec_t vecs [8];

    int          passed;
    int          total;
    int          cyc;
    logic [15:0] bits_cur;
    int          nbits_cur;
    int          bit_idx;
    int          gap_cur;
    int          gap_left;
    logic        fire_b;
    int          stall_left;
    logic        stall_started;
    logic [7:0]  stall_char;
    logic        stall_viol;
    logic        mem_pend;
    logic [6:0]  mem_paddr;
    logic        mem_viol;
    logic        got_first;
    logic [6:0]  first_addr;
    logic [7:0]  rx [0:7];
    int          rx_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [8:0] lf(input logic [7:0] c);
        return {1'b0, c};
    endfunction

    function automatic logic [8:0] nx(input logic [6:0] i);
        return {2'b10, i};
    endfunction

    function automatic logic [70:0] nd(input logic [8:0] l, input logic [8:0] r);
        return {7'd8, l, r, 46'd0};
    endfunction

    task automatic load_tree(input int sel);
        for (int i = 0; i < 128; i++) mem[i] = '0;
        if (sel == 1) begin
            mem[0] = {7'd0, lf(8'd67), 9'h180, 46'd0};
        end else begin
            mem[8] = nd(nx(7'd7), nx(7'd6));
            mem[7] = nd(nx(7'd3), nx(7'd2));
            mem[6] = nd(lf(8'd74), nx(7'd5));      // J = 10
            mem[5] = nd(lf(8'd71), nx(7'd4));      // G = 110
            mem[4] = nd(lf(8'd72), lf(8'd73));     // H = 1110, I = 1111
            mem[3] = nd(nx(7'd1), lf(8'd65));      // A = 001
            mem[2] = nd(lf(8'd70), nx(7'd0));      // F = 010
            mem[1] = nd(lf(8'd67), lf(8'd66));     // C = 0000, B = 0001
            mem[0] = nd(lf(8'd68), lf(8'd69));     // D = 0110, E = 0111
            if (sel == 2) mem[6] = nd(lf(8'd74), 9'h114);
        end
    endtask

    task automatic setup(input vec_t v);
        load_tree(v.tree);
        mem_delay     = v.delay;
        bits_cur      = v.bits;
        nbits_cur     = v.nbits;
        bit_idx       = 0;
        gap_cur       = v.gap;
        gap_left      = 0;
        fire_b        = 1'b0;
        bit_valid     = 1'b0;
        bit_in        = 1'b0;
        char_ready    = 1'b1;
        stall_left    = v.stall;
        stall_started = 1'b0;
        stall_char    = '0;
        stall_viol    = 1'b0;
        mem_pend      = 1'b0;
        mem_paddr     = '0;
        mem_viol      = 1'b0;
        got_first     = 1'b0;
        first_addr    = '0;
        rx_cnt        = 0;
        for (int i = 0; i < 8; i++) rx[i] = '0;
        max_index     = v.root;
        num_chars     = v.nch;
    endtask

    // One cycle: everything is driven and observed at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (fire_b) begin
            bit_idx++;
            gap_left = gap_cur;
        end
        if (bit_idx < nbits_cur && gap_left == 0) begin
            bit_valid = 1'b1;
            bit_in    = bits_cur[nbits_cur-1-bit_idx];
        end else begin
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            if (gap_left > 0) gap_left--;
        end
        fire_b = bit_valid && bit_ready;

        char_ready = 1'b1;
        if (stall_left > 0 && (char_valid || stall_started)) begin
            if (!stall_started) begin
                stall_started = 1'b1;
                stall_char    = char_out;
            end
            if (!char_valid || char_out != stall_char || bit_ready) stall_viol = 1'b1;
            char_ready = 1'b0;
            stall_left--;
        end
        if (char_valid && char_ready) begin
            if (rx_cnt < 8) rx[rx_cnt] = char_out;
            rx_cnt++;
        end

        if (mem_pend && (!node_req || node_addr != mem_paddr)) mem_viol = 1'b1;
        mem_pend  = node_req && !node_ack;
        mem_paddr = node_addr;
        if (node_req && !got_first) begin
            got_first  = 1'b1;
            first_addr = node_addr;
        end
    endtask

    task automatic run(input vec_t v, input int vi);
        int exp_n;
        setup(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && !err && cyc < 500) begin
            tick();
            cyc++;
        end
        exp_n = v.exp_err ? 0 : int'(v.nch);
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("v%0d char%0d", vi, i), 64'(rx[i]), 64'(v.exp_chars[31-8*i -: 8]));
        end
        check($sformatf("v%0d rx_count", vi), 64'(rx_cnt), 64'(exp_n));
        check($sformatf("v%0d chars_done", vi), 64'(chars_done), 64'(exp_n));
        check($sformatf("v%0d done", vi), 64'(done), 64'(!v.exp_err));
        check($sformatf("v%0d err", vi), 64'(err), 64'(v.exp_err));
        check($sformatf("v%0d bits_used", vi), 64'(bit_idx), 64'(v.nbits));
        check($sformatf("v%0d node_stable", vi), 64'(mem_viol), 64'd0);
        if (v.nch != 0) check($sformatf("v%0d first_addr", vi), 64'(first_addr), 64'(v.root));
        if (v.stall > 0) begin
            check($sformatf("v%0d stall_hold", vi), 64'(stall_viol), 64'd0);
            check($sformatf("v%0d stall_seen", vi), 64'(stall_started), 64'd1);
        end
        if (v.exp_cyc > 0) check($sformatf("v%0d cycles", vi), 64'(cyc), 64'(v.exp_cyc));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        vecs[0] = '{0, 7'd8, 16'd3, 16'b100010000, 9, 0, 0, 0,
                    {8'd74, 8'd65, 8'd67, 8'd0}, 1'b0, 22};
        vecs[1] = '{1, 7'd0, 16'd3, 16'b010, 3, 0, 0, 0,
                    {8'd67, 8'd67, 8'd67, 8'd0}, 1'b0, 10};
        vecs[2] = '{0, 7'd8, 16'd3, 16'b100010000, 9, 0, 0, 5,
                    {8'd74, 8'd65, 8'd67, 8'd0}, 1'b0, 0};
        vecs[3] = '{0, 7'd8, 16'd3, 16'b100010000, 9, 0, 3, 0,
                    {8'd74, 8'd65, 8'd67, 8'd0}, 1'b0, 0};
        vecs[4] = '{0, 7'd8, 16'd3, 16'b100010000, 9, 4, 0, 0,
                    {8'd74, 8'd65, 8'd67, 8'd0}, 1'b0, 58};
        vecs[5] = '{0, 7'd8, 16'd4, 16'b1110111100010111, 16, 0, 0, 0,
                    {8'd72, 8'd73, 8'd66, 8'd69}, 1'b0, 37};
        vecs[6] = '{0, 7'd8, 16'd0, 16'd0, 0, 0, 0, 0, 32'd0, 1'b0, 1};
        vecs[7] = '{2, 7'd8, 16'd2, 16'b11, 2, 0, 0, 0, 32'd0, 1'b1, 5};
        setup(vecs[0]);

        tick();
        tick();
        check("reset outputs", {bit_ready, node_req, node_addr, char_out, char_valid, done, err,
                                chars_done}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle quiet %0d", i), {bit_ready, node_req, done, err}, 64'd0);
        end

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        // Error state ignores start and keeps every handshake low.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("err sticky", 64'(err), 64'd1);
        check("err quiet", {node_req, bit_ready, char_valid, done}, 64'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("err cleared", 64'(err), 64'd0);

        // Abort a walk part-way through the second symbol.
        setup(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midwalk count", 64'(chars_done), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort outputs", {bit_ready, node_req, node_addr, char_out, char_valid, done, err,
                                chars_done}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run(vecs[0], 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
